// File: rtl/seq_alu_acc_pkg.sv
// Shared definitions for the sequential ALU/accumulator: function codes and FSM states.
package seq_alu_acc_pkg;

  localparam logic [2:0] FN_ADD  = 3'd0;
  localparam logic [2:0] FN_SUB  = 3'd1;
  localparam logic [2:0] FN_MUL  = 3'd2;
  localparam logic [2:0] FN_SEXT = 3'd3;
  localparam logic [2:0] FN_OR   = 3'd4;
  localparam logic [2:0] FN_AND  = 3'd5;
  localparam logic [2:0] FN_CAT  = 3'd6;
  localparam logic [2:0] FN_HOLD = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/seq_alu_acc_if.sv
// Operand/handshake/result bundle between the switch/key inputs and the accumulator.
interface seq_alu_acc_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0]   Data;
  logic [2:0]         Function;
  logic               Go;
  logic               Busy;
  logic               Done;
  logic [2*WIDTH-1:0] ALUout;

  modport master (
    output Data, Function, Go,
    input  Busy, Done, ALUout
  );

  modport slave (
    input  Data, Function, Go,
    output Busy, Done, ALUout
  );
endinterface

// File: rtl/seq_alu_acc_shift_add_mult.sv
// Unsigned WIDTH x WIDTH shift-add multiplier, one iteration per clock.
module shift_add_mult #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               Clock,
  input  logic               Reset_b,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] addend;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  // product is the value the accumulator takes at the end of the current
  // iteration, so the final iteration's result is usable on the same edge.
  assign addend  = mplier[0] ? mcand : '0;
  assign product = acc + addend;
  assign last    = busy && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (last) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_alu_acc.sv
// Accumulating ALU: single-cycle ops write ALUout on accept, MUL runs WIDTH cycles.
module seq_alu_acc
  import seq_alu_acc_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic         Clock,
  input  logic         Reset_b,
  seq_alu_acc_if.slave bus
);

  localparam int unsigned W2 = 2 * WIDTH;

  state_t          state, state_nxt;
  logic [W2-1:0]   alu_q, alu_nxt, sc_res;
  logic            done_q, done_nxt;
  logic            mul_start, mul_busy, mul_last;
  logic [W2-1:0]   mul_product;
  logic [WIDTH-1:0] op_a, op_b;

  assign op_a = bus.Data;
  assign op_b = alu_q[WIDTH-1:0];

  always_comb begin
    sc_res = alu_q;
    case (bus.Function)
      FN_ADD:  sc_res = {{WIDTH{1'b0}}, op_a} + {{WIDTH{1'b0}}, op_b};
      FN_SUB:  sc_res = {{WIDTH{1'b0}}, op_a} - {{WIDTH{1'b0}}, op_b};
      FN_SEXT: sc_res = {{WIDTH{op_b[WIDTH-1]}}, op_b};
      FN_OR:   sc_res = {{(W2-1){1'b0}}, |{op_a, op_b}};
      FN_AND:  sc_res = {{(W2-1){1'b0}}, &{op_a, op_b}};
      FN_CAT:  sc_res = {op_a, op_b};
      default: sc_res = alu_q;
    endcase
  end

  shift_add_mult #(
    .WIDTH(WIDTH)
  ) u_mult (
    .Clock   (Clock),
    .Reset_b (Reset_b),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .last    (mul_last),
    .product (mul_product)
  );

  always_comb begin
    state_nxt = state;
    alu_nxt   = alu_q;
    done_nxt  = 1'b0;
    mul_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.Go) begin
          if (bus.Function == FN_MUL) begin
            mul_start = 1'b1;
            state_nxt = ST_MUL;
          end else begin
            alu_nxt  = sc_res;
            done_nxt = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_last) begin
          alu_nxt   = mul_product;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (!mul_busy) begin
          // multiplier lost its job without finishing; recover without a result
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state  <= ST_IDLE;
      alu_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      alu_q  <= alu_nxt;
      done_q <= done_nxt;
    end
  end

  assign bus.ALUout = alu_q;
  assign bus.Done   = done_q;
  assign bus.Busy   = (state == ST_MUL);

endmodule

// File: tb/tb_seq_alu_acc.sv
// Directed-vector bench for seq_alu_acc at WIDTH=4 with hand-computed results.
module tb_seq_alu_acc;
  import seq_alu_acc_pkg::*;

  logic Clock;
  logic Reset_b;
  int   n_checks = 0;
  int   n_errors = 0;

  seq_alu_acc_if #(.WIDTH(4)) bus ();

  seq_alu_acc #(
    .WIDTH(4)
  ) dut (
    .Clock   (Clock),
    .Reset_b (Reset_b),
    .bus     (bus)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [7:0] alu, input logic busy, input logic done);
    check_val({tag, "_alu"},  16'(bus.ALUout), 16'(alu));
    check_val({tag, "_busy"}, 16'(bus.Busy),   16'(busy));
    check_val({tag, "_done"}, 16'(bus.Done),   16'(done));
  endtask

  // One single-cycle op: accept, expect result with a Done pulse, then Done low.
  task automatic op1(input logic [3:0] d, input logic [2:0] f, input logic [7:0] exp, input string tag);
    bus.Data     = d;
    bus.Function = f;
    bus.Go       = 1'b1;
    step();
    bus.Go = 1'b0;
    check_outs(tag, exp, 1'b0, 1'b1);
    step();
    check_val({tag, "_done_end"}, 16'(bus.Done), 16'd0);
  endtask

  initial begin
    Reset_b      = 1'b0;
    bus.Go       = 1'b0;
    bus.Data     = '0;
    bus.Function = FN_ADD;
    #2;
    check_outs("reset", 8'h00, 1'b0, 1'b0);
    #10 Reset_b = 1'b1;

    op1(4'd3, FN_ADD, 8'h03, "add3");
    op1(4'd5, FN_ADD, 8'h08, "add5");
    op1(4'd5, FN_ADD, 8'h0D, "add_0d");

    // MUL 0xB * 0xD, with Go/Data/Function wiggling while busy
    bus.Data     = 4'hB;
    bus.Function = FN_MUL;
    bus.Go       = 1'b1;
    step();
    check_outs("mul_c1", 8'h0D, 1'b1, 1'b0);
    bus.Go = 1'b0; bus.Data = 4'h7;
    step();
    check_outs("mul_c2", 8'h0D, 1'b1, 1'b0);
    bus.Go = 1'b1; bus.Function = FN_ADD;
    step();
    check_outs("mul_c3", 8'h0D, 1'b1, 1'b0);
    bus.Go = 1'b0; bus.Data = 4'h1; bus.Function = FN_CAT;
    step();
    check_outs("mul_c4", 8'h0D, 1'b1, 1'b0);
    step();
    check_outs("mul_c5", 8'h8F, 1'b0, 1'b1);
    step();
    check_outs("mul_c6", 8'h8F, 1'b0, 1'b0);

    op1(4'd0, FN_AND, 8'h00, "clr1");
    op1(4'd5, FN_ADD, 8'h05, "set5");
    op1(4'd3, FN_SUB, 8'hFE, "sub");

    op1(4'd0, FN_AND,  8'h00, "clr2");
    op1(4'd9, FN_ADD,  8'h09, "set9");
    op1(4'd0, FN_SEXT, 8'hF9, "sext");
    op1(4'd3, FN_HOLD, 8'hF9, "hold");

    op1(4'd0, FN_AND, 8'h00, "clr3");
    op1(4'd5, FN_ADD, 8'h05, "set5b");
    op1(4'hA, FN_CAT, 8'hA5, "cat");

    op1(4'd0, FN_AND, 8'h00, "clr4");
    op1(4'hF, FN_ADD, 8'h0F, "setf");
    op1(4'hF, FN_AND, 8'h01, "and_ones");
    op1(4'd0, FN_OR,  8'h01, "or_one");
    op1(4'd0, FN_AND, 8'h00, "and_zero");
    op1(4'd0, FN_OR,  8'h00, "or_zero");
    op1(4'hE, FN_ADD, 8'h0E, "sete");

    // Go held high: back-to-back accumulation with feedback wrap
    bus.Data = 4'd1; bus.Function = FN_ADD; bus.Go = 1'b1;
    step();
    check_outs("held1", 8'h0F, 1'b0, 1'b1);
    step();
    check_outs("held2", 8'h10, 1'b0, 1'b1);
    step();
    check_outs("held3", 8'h01, 1'b0, 1'b1);
    bus.Go = 1'b0;

    // asynchronous reset mid-cycle while Done is high
    #2 Reset_b = 1'b0;
    #1;
    check_outs("async_rst", 8'h00, 1'b0, 1'b0);
    step();
    check_outs("rst_held", 8'h00, 1'b0, 1'b0);
    #3 Reset_b = 1'b1;
    step();
    check_outs("rst_rel", 8'h00, 1'b0, 1'b0);

    // reset during the second Busy cycle of a MUL
    op1(4'd3, FN_ADD, 8'h03, "pre_mul");
    bus.Data = 4'd5; bus.Function = FN_MUL; bus.Go = 1'b1;
    step();
    bus.Go = 1'b0;
    check_outs("mr_c1", 8'h03, 1'b1, 1'b0);
    step();
    check_outs("mr_c2", 8'h03, 1'b1, 1'b0);
    #2 Reset_b = 1'b0;
    #1;
    check_outs("mr_rst", 8'h00, 1'b0, 1'b0);
    step();
    #3 Reset_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_outs("mr_quiet", 8'h00, 1'b0, 1'b0);
    end
    op1(4'd6, FN_ADD, 8'h06, "post_rst_add");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
